// File: rtl/pc_sequencer.sv
// Instruction sequencer driving the ProgramCounter control lines from fetched words,
// with an ALU start/busy handshake and a hardware return-address stack for CALL/RET.
module pc_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int W           = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [W-1:0]                  pc_value,
    input  logic [W-1:0]                  instr,
    input  logic                          instr_valid,
    input  logic                          alu_busy,
    input  logic                          zero_flag,
    output logic                          pc_w,
    output logic                          pc_bra,
    output logic                          pc_stack_pop,
    output logic                          pc_fact,
    output logic [W-1:0]                  pc_in,
    output logic [W-1:0]                  ir,
    output logic                          alu_start,
    output logic                          halted,
    output logic                          stack_overflow,
    output logic                          stack_underflow,
    output logic [$clog2(STACK_DEPTH):0]  depth
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_OPERAND = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [1:0]    state, nxt;
    logic [W-1:0]  stack_mem [STACK_DEPTH];
    logic [AW-1:0] top_idx;
    logic [W-1:0]  top;
    logic [3:0]    op_f, op_ir;
    logic          empty, full;

    logic          hold, w_c, bra_c, pop_c;
    logic [W-1:0]  in_c;
    logic          push, pop, ld_ir, start_nxt, set_ovf, set_unf;

    assign op_f    = instr[W-1 -: 4];
    assign op_ir   = ir[W-1 -: 4];
    assign top_idx = depth[AW-1:0] - AW'(1);
    assign top     = stack_mem[top_idx];
    assign empty   = (depth == '0);
    assign full    = (depth == DW'(STACK_DEPTH));

    always_comb begin
        hold      = 1'b0;
        w_c       = 1'b0;
        bra_c     = 1'b0;
        pop_c     = 1'b0;
        in_c      = '0;
        nxt       = state;
        push      = 1'b0;
        pop       = 1'b0;
        ld_ir     = 1'b0;
        start_nxt = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (state)
            S_FETCH: begin
                if (!instr_valid) begin
                    hold = 1'b1;
                end else begin
                    ld_ir = 1'b1;
                    if (!op_f[3]) begin
                        start_nxt = 1'b1;
                        nxt       = S_WAIT;
                    end else begin
                        case (op_f)
                            OP_JMP, OP_JZ, OP_CALL: nxt = S_OPERAND;
                            OP_RET: begin
                                if (!empty) begin
                                    // PC adds 2 on a stack pop, landing past the CALL operand
                                    w_c   = 1'b1;
                                    pop_c = 1'b1;
                                    in_c  = top;
                                    pop   = 1'b1;
                                end else begin
                                    hold    = 1'b1;
                                    set_unf = 1'b1;
                                    nxt     = S_HALT;
                                end
                            end
                            OP_HALT: begin
                                hold = 1'b1;
                                nxt  = S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_OPERAND: begin
                if (!instr_valid) begin
                    hold = 1'b1;
                end else begin
                    nxt = S_FETCH;
                    case (op_ir)
                        OP_JMP: begin
                            w_c   = 1'b1;
                            bra_c = 1'b1;
                            in_c  = instr;
                        end
                        OP_JZ: begin
                            if (zero_flag) begin
                                w_c   = 1'b1;
                                bra_c = 1'b1;
                                in_c  = instr;
                            end
                        end
                        OP_CALL: begin
                            if (!full) begin
                                push  = 1'b1;
                                w_c   = 1'b1;
                                bra_c = 1'b1;
                                in_c  = instr;
                            end else begin
                                hold    = 1'b1;
                                set_ovf = 1'b1;
                                nxt     = S_HALT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                hold = 1'b1;
                // alu_start is high only in the first wait cycle, when busy is not yet meaningful
                if (!alu_start && !alu_busy) nxt = S_FETCH;
            end
            S_HALT: hold = 1'b1;
            default: nxt = S_FETCH;
        endcase
        if (hold) begin
            w_c   = 1'b1;
            bra_c = 1'b1;
            in_c  = pc_value;
        end
    end

    assign pc_w         = RESET & w_c;
    assign pc_bra       = RESET & bra_c;
    assign pc_stack_pop = RESET & pop_c;
    assign pc_fact      = 1'b0;
    assign pc_in        = RESET ? in_c : '0;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state           <= S_FETCH;
            ir              <= '0;
            alu_start       <= 1'b0;
            halted          <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            depth           <= '0;
        end else begin
            state     <= nxt;
            alu_start <= start_nxt;
            halted    <= (nxt == S_HALT);
            if (ld_ir)   ir              <= instr;
            if (set_ovf) stack_overflow  <= 1'b1;
            if (set_unf) stack_underflow <= 1'b1;
            if (push)     depth <= depth + DW'(1);
            else if (pop) depth <= depth - DW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && push) stack_mem[depth[AW-1:0]] <= pc_value - W'(1);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a ProgramCounter/memory/ALU environment, a rule-level reference
// model checked every cycle, and directed program scenarios with literal expectations.
module tb_pc_sequencer;
    localparam int W  = 16;
    localparam int SD = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [W-1:0]  pc = '0;
    logic [W-1:0]  instr;
    logic          instr_valid = 1'b1;
    logic          alu_busy = 1'b0;
    logic          zero_flag;
    logic          pc_w, pc_bra, pc_stack_pop, pc_fact;
    logic [W-1:0]  pc_in, ir;
    logic          alu_start, halted, stack_overflow, stack_underflow;
    logic [3:0]    depth;

    logic [W-1:0]  mem [0:1023];
    int            total = 0;
    int            bad = 0;

    assign instr     = mem[pc[9:0]];
    assign zero_flag = (pc == 16'h000A);

    always #5 CLK = ~CLK;

    pc_sequencer #(.STACK_DEPTH(SD), .W(W)) dut (
        .CLK(CLK), .RESET(RESET), .pc_value(pc), .instr(instr),
        .instr_valid(instr_valid), .alu_busy(alu_busy), .zero_flag(zero_flag),
        .pc_w(pc_w), .pc_bra(pc_bra), .pc_stack_pop(pc_stack_pop), .pc_fact(pc_fact),
        .pc_in(pc_in), .ir(ir), .alu_start(alu_start), .halted(halted),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow), .depth(depth)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ProgramCounter environment
    initial forever begin : pc_env
        logic [W-1:0] nx;
        @(posedge CLK);
        if (!RESET)                    nx = '0;
        else if (pc_w && pc_bra)       nx = pc_in;
        else if (pc_w && pc_stack_pop) nx = pc_in + 16'd2;
        else                           nx = pc + 16'd1;
        #1 pc = nx;
    end

    // ALU environment: busy for 4 cycles following the start cycle
    initial forever begin : alu_env
        int acnt;
        acnt = 0;
        forever begin
            @(posedge CLK);
            if (!RESET)         acnt = 0;
            else if (alu_start) acnt = 4;
            else if (acnt > 0)  acnt--;
            #1 alu_busy = (acnt > 0);
        end
    end

    // Reference model, applied from the instruction-set rules
    logic          m_halt = 0, m_ovf = 0, m_unf = 0, m_start = 0;
    logic [W-1:0]  m_ir = '0;
    logic [W-1:0]  stk[$];
    int            m_pend = -1;
    int            m_alu = 0;

    initial forever begin : model
        logic e_w, e_bra, e_pop;
        logic [W-1:0] e_in;
        int op;
        @(negedge CLK);
        chk("ir", ir, m_ir);
        chk("alu_start", alu_start, m_start);
        chk("halted", halted, m_halt);
        chk("overflow", stack_overflow, m_ovf);
        chk("underflow", stack_underflow, m_unf);
        chk("depth", depth, stk.size());
        e_w = 0; e_bra = 0; e_pop = 0; e_in = '0;
        if (!RESET) begin
            m_halt = 0; m_ovf = 0; m_unf = 0; m_start = 0; m_ir = '0;
            stk.delete(); m_pend = -1; m_alu = 0;
        end else begin
            m_start = 0;
            if (m_halt) begin
                e_w = 1; e_bra = 1; e_in = pc;
            end else if (m_alu != 0) begin
                e_w = 1; e_bra = 1; e_in = pc;
                if (m_alu == 1) m_alu = 2;
                else if (!alu_busy) m_alu = 0;
            end else if (m_pend >= 0) begin
                if (!instr_valid) begin
                    e_w = 1; e_bra = 1; e_in = pc;
                end else begin
                    if (m_pend == 8 || (m_pend == 9 && zero_flag)) begin
                        e_w = 1; e_bra = 1; e_in = instr;
                    end else if (m_pend == 10) begin
                        if (stk.size() < SD) begin
                            stk.push_back(pc - 16'd1);
                            e_w = 1; e_bra = 1; e_in = instr;
                        end else begin
                            e_w = 1; e_bra = 1; e_in = pc; m_ovf = 1; m_halt = 1;
                        end
                    end
                    m_pend = -1;
                end
            end else if (!instr_valid) begin
                e_w = 1; e_bra = 1; e_in = pc;
            end else begin
                op = int'(instr[15:12]);
                m_ir = instr;
                if (op < 8) begin
                    m_start = 1; m_alu = 1;
                end else if (op >= 8 && op <= 10) begin
                    m_pend = op;
                end else if (op == 11) begin
                    if (stk.size() > 0) begin
                        e_w = 1; e_pop = 1; e_in = stk.pop_back();
                    end else begin
                        e_w = 1; e_bra = 1; e_in = pc; m_unf = 1; m_halt = 1;
                    end
                end else if (op == 15) begin
                    e_w = 1; e_bra = 1; e_in = pc; m_halt = 1;
                end
            end
        end
        chk("pc_w", pc_w, e_w);
        chk("pc_bra", pc_bra, e_bra);
        chk("pc_stack_pop", pc_stack_pop, e_pop);
        chk("pc_fact", pc_fact, 1'b0);
        chk("pc_in", pc_in, e_in);
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_pc(input logic [W-1:0] t, input int budget, input string nm);
        logic ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (pc == t) begin ok = 1; break; end
            tick();
        end
        chk(nm, ok, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int c9, st;
        logic ok;
        for (int i = 0; i < 1024; i++) mem[i] = 16'hC000;
        mem[16'h004] = 16'h8000; mem[16'h005] = 16'h0040;
        mem[16'h040] = 16'h8000; mem[16'h041] = 16'h0006;
        mem[16'h006] = 16'h9000; mem[16'h007] = 16'h0020;
        mem[16'h008] = 16'h3000;
        mem[16'h009] = 16'h9000; mem[16'h00A] = 16'h0010;
        mem[16'h010] = 16'hA000; mem[16'h011] = 16'h0100;
        mem[16'h100] = 16'hB000;
        mem[16'h012] = 16'hA000; mem[16'h013] = 16'h0200;
        for (int k = 0; k < 8; k++) begin
            mem[16'h200 + 2*k]     = 16'hA000;
            mem[16'h201 + 2*k]     = 16'h0202 + 16'(2*k);
        end

        RESET = 0;
        repeat (3) tick();
        chk("rst_halted", halted, 1'b0);
        chk("rst_depth", depth, 4'd0);
        chk("rst_pc_w", pc_w, 1'b0);
        RESET = 1;
        #1 chk("nop_pc0", pc, 16'h0000);
        chk("nop_pc_w", pc_w, 1'b0);
        tick(); chk("nop_pc1", pc, 16'h0001);
        tick(); chk("nop_pc2", pc, 16'h0002);

        instr_valid = 0;
        #1 chk("stall_w", pc_w, 1'b1);
        chk("stall_bra", pc_bra, 1'b1);
        chk("stall_in", pc_in, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_pc", pc, 16'h0002);
            if (i == 2) instr_valid = 1;
        end
        tick(); chk("resume_pc3", pc, 16'h0003);

        wait_pc(16'h0040, 10, "jmp_target");
        chk("jmp_ir", ir, 16'h8000);
        tick(); tick(); chk("jmp2_pc6", pc, 16'h0006);
        tick(); chk("jz_operand_pc7", pc, 16'h0007);
        tick(); chk("jz_skip_pc8", pc, 16'h0008);
        tick(); chk("alu_pc9", pc, 16'h0009);
        chk("alu_start_pulse", alu_start, 1'b1);

        c9 = 0; st = 0;
        for (int i = 0; i < 20; i++) begin
            if (pc != 16'h0009) break;
            c9++;
            if (alu_start) st++;
            tick();
        end
        chk("alu_hold_cycles", c9, 7);
        chk("alu_start_count", st, 1);
        chk("after_alu_pcA", pc, 16'h000A);
        tick(); chk("jz_taken_pc10", pc, 16'h0010);

        wait_pc(16'h0100, 10, "call_target");
        chk("call_depth", depth, 4'd1);
        #1 chk("ret_pop", pc_stack_pop, 1'b1);
        chk("ret_in", pc_in, 16'h0010);
        tick(); chk("ret_pc", pc, 16'h0012);
        chk("ret_depth", depth, 4'd0);

        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (halted) begin ok = 1; break; end
            tick();
        end
        chk("ovf_halt_seen", ok, 1'b1);
        chk("ovf_flag", stack_overflow, 1'b1);
        chk("ovf_depth", depth, 4'd8);
        chk("ovf_pc", pc, 16'h020F);
        repeat (3) tick();
        chk("ovf_pc_frozen", pc, 16'h020F);

        RESET = 0;
        mem[0] = 16'hB000;
        #1 chk("rst_force_w", pc_w, 1'b0);
        chk("rst_force_in", pc_in, 16'h0000);
        tick();
        chk("rst2_halted", halted, 1'b0);
        chk("rst2_ovf", stack_overflow, 1'b0);
        chk("rst2_depth", depth, 4'd0);
        chk("rst2_pc", pc, 16'h0000);
        RESET = 1;
        tick(); tick();
        chk("unf_flag", stack_underflow, 1'b1);
        chk("unf_halted", halted, 1'b1);
        chk("unf_pc", pc, 16'h0000);

        RESET = 0;
        tick();
        mem[0] = 16'hC000;
        chk("rst3_unf", stack_underflow, 1'b0);
        chk("rst3_halted", halted, 1'b0);
        RESET = 1;
        tick(); chk("rst3_pc1", pc, 16'h0001);
        tick(); chk("rst3_pc2", pc, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
